// File: rtl/octree_mem_responder.sv
// Word-addressed memory model on the responder side of the octree core's
// single-port SRAM bus. It handles writes in the cycle they are sampled. Reads
// return after READ_LATENCY cycles through an in-order pipeline. The block also
// provides a preload port, saturating access counters and sticky error flags.
//
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   mem_sram_CEN/GWEN/A/D        bus request (CEN active-low, GWEN 0 = write)
//   mem_sram_Q, q_valid          read data and 1-cycle result strobe
//   load_en/load_idx/load_data   preload write, word indexed (no BASE_ADDR)
//   err_clr, err_oob, err_collide  sticky error flags and their clear
//   rd_count, wr_count           accepted reads/writes, saturating
module octree_mem_responder #(
  parameter int unsigned     DATA_BUS_WIDTH = 64,
  parameter int unsigned     ADDR_BUS_WIDTH = 64,
  parameter int unsigned     DEPTH          = 1024,
  parameter longint unsigned BASE_ADDR      = 0,
  parameter int unsigned     READ_LATENCY   = 1,  // legal range 1..4
  parameter int unsigned     CNT_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_sram_CEN,
  input  logic                       mem_sram_GWEN,
  input  logic [ADDR_BUS_WIDTH-1:0]  mem_sram_A,
  input  logic [DATA_BUS_WIDTH-1:0]  mem_sram_D,
  output logic [DATA_BUS_WIDTH-1:0]  mem_sram_Q,
  output logic                       q_valid,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_idx,
  input  logic [DATA_BUS_WIDTH-1:0]  load_data,
  input  logic                       err_clr,
  output logic                       err_oob,
  output logic                       err_collide,
  output logic [CNT_WIDTH-1:0]       rd_count,
  output logic [CNT_WIDTH-1:0]       wr_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_BUS_WIDTH-1:0] BASE_A  = ADDR_BUS_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_BUS_WIDTH-1:0] DEPTH_A = ADDR_BUS_WIDTH'(DEPTH);

  logic [DATA_BUS_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_BUS_WIDTH-1:0] idx_full;
  logic [IDX_W-1:0]          idx;
  logic                      in_range;
  logic                      load_ok;
  logic                      collide;
  logic                      bus_acc;
  logic                      wr_ok;
  logic                      rd_acc;
  logic                      rd_ok;
  logic                      oob;
  logic [DATA_BUS_WIDTH-1:0] rd_data;
  logic                      res_vld;
  logic [DATA_BUS_WIDTH-1:0] res_data;

  always_comb begin
    idx_full = mem_sram_A - BASE_A;
    idx      = idx_full[IDX_W-1:0];
    in_range = (mem_sram_A >= BASE_A) && (idx_full < DEPTH_A);
    load_ok  = load_en && (32'(load_idx) < DEPTH);
    // A valid preload owns the array this cycle; the bus access is dropped whole.
    collide  = !mem_sram_CEN && load_ok;
    bus_acc  = !mem_sram_CEN && !load_ok;
    wr_ok    = bus_acc && !mem_sram_GWEN && in_range;
    rd_acc   = bus_acc && mem_sram_GWEN;
    rd_ok    = rd_acc && in_range;
    oob      = bus_acc && !in_range;
    // Out-of-range reads still travel the pipeline, carrying zero.
    rd_data  = rd_ok ? mem[idx] : '0;
  end

  // Array is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem[load_idx] <= load_data;
    end else if (wr_ok) begin
      mem[idx] <= mem_sram_D;
    end
  end

  // READ_LATENCY-1 stages sit between the capture edge and the Q register.
  if (READ_LATENCY == 1) begin : g_direct
    assign res_vld  = rd_acc;
    assign res_data = rd_data;
  end else begin : g_pipe
    localparam int unsigned N = READ_LATENCY - 1;
    logic [N-1:0]              vld;
    logic [DATA_BUS_WIDTH-1:0] data [N];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld <= '0;
        for (int i = 0; i < int'(N); i++) data[i] <= '0;
      end else begin
        vld[0]  <= rd_acc;
        data[0] <= rd_data;
        for (int i = 1; i < int'(N); i++) begin
          vld[i]  <= vld[i-1];
          data[i] <= data[i-1];
        end
      end
    end

    assign res_vld  = vld[N-1];
    assign res_data = data[N-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_sram_Q  <= '0;
      q_valid     <= 1'b0;
      err_oob     <= 1'b0;
      err_collide <= 1'b0;
      rd_count    <= '0;
      wr_count    <= '0;
    end else begin
      q_valid <= res_vld;
      if (res_vld) mem_sram_Q <= res_data;

      if (rd_ok && (rd_count != '1)) rd_count <= rd_count + 1'b1;
      if (wr_ok && (wr_count != '1)) wr_count <= wr_count + 1'b1;

      // Clear first so that a same-cycle error event wins.
      if (err_clr) begin
        err_oob     <= 1'b0;
        err_collide <= 1'b0;
      end
      if (oob)     err_oob     <= 1'b1;
      if (collide) err_collide <= 1'b1;
    end
  end

endmodule
